// File: rtl/d_ff_pkg.sv
// Shared definitions for the d_ff reference register block.
// Holds the reset-style enumeration and the default reset value.
package d_ff_pkg;

  typedef enum logic [1:0] {
    RST_NONE  = 2'd0,
    RST_SYNC  = 2'd1,
    RST_ASYNC = 2'd2
  } rst_style_e;

  localparam int unsigned MAX_WIDTH = 64;

  // Wide zero constant; instances slice off the bits they need.
  localparam logic [MAX_WIDTH-1:0] DEFAULT_RESET_VAL = {MAX_WIDTH{1'b0}};

endpackage

// File: rtl/dff_cell.sv
// Single D flip-flop bank whose reset behaviour is chosen by STYLE.
// Exactly one always_ff is elaborated, with a sensitivity list matching the style.
module dff_cell
  import d_ff_pkg::*;
#(
  parameter int unsigned         WIDTH     = 1,
  parameter logic [WIDTH-1:0]    RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0],
  parameter rst_style_e          STYLE     = RST_NONE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  if (STYLE == RST_ASYNC) begin : g_async
    // Reset acts on its falling edge without waiting for the clock.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q <= RESET_VAL;
      end else begin
        r_q <= d_in;
      end
    end
  end else if (STYLE == RST_SYNC) begin : g_sync
    // Reset is only sampled at the rising clock edge.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_q <= RESET_VAL;
      end else begin
        r_q <= d_in;
      end
    end
  end else begin : g_none
    // Plain capture flop; the reset pin is intentionally left without effect.
    logic w_unused_rst;
    assign w_unused_rst = reset;

    always_ff @(posedge clk) begin
      r_q <= d_in;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/d_ff.sv
// Reference register block: three flops fed by one d_in, one per reset style.
// Outputs come straight from flops; there is no combinational d_in -> q path.
module d_ff
  import d_ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = DEFAULT_RESET_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_no_reset,
  output logic [WIDTH-1:0] q_sync_reset,
  output logic [WIDTH-1:0] q_async_reset
);

  dff_cell #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .STYLE     (RST_NONE)
  ) u_no_reset (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .q     (q_no_reset)
  );

  dff_cell #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .STYLE     (RST_SYNC)
  ) u_sync_reset (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .q     (q_sync_reset)
  );

  dff_cell #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL),
    .STYLE     (RST_ASYNC)
  ) u_async_reset (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .q     (q_async_reset)
  );

endmodule

// File: tb/tb_d_ff.sv
// Self-checking bench for d_ff: a 1-bit default instance and an 8-bit instance
// with reset value 8'hA5, checked against a rule-level model of the three flop styles.
module tb_d_ff;

  localparam logic [0:0] RV1 = 1'b0;
  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [0:0] d1 = 1'b0;
  logic [7:0] d8 = 8'h3C;

  logic [0:0] q_nr1, q_sr1, q_ar1;
  logic [7:0] q_nr8, q_sr8, q_ar8;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Model state: what each flop style should hold right now.
  logic [0:0] m_nr1 = 1'b0, m_sr1 = 1'b0, m_ar1 = 1'b0;
  logic [7:0] m_nr8 = 8'h00, m_sr8 = 8'h00, m_ar8 = 8'h00;

  always #5 clk = ~clk;

  d_ff u_dut1 (
    .clk           (clk),
    .reset         (reset),
    .d_in          (d1),
    .q_no_reset    (q_nr1),
    .q_sync_reset  (q_sr1),
    .q_async_reset (q_ar1)
  );

  d_ff #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) u_dut8 (
    .clk           (clk),
    .reset         (reset),
    .d_in          (d8),
    .q_no_reset    (q_nr8),
    .q_sync_reset  (q_sr8),
    .q_async_reset (q_ar8)
  );

  // Model rules at a rising edge: inputs are only changed away from edges.
  always @(posedge clk) begin
    m_nr1 = d1;
    m_nr8 = d8;
    m_sr1 = reset ? d1 : RV1;
    m_sr8 = reset ? d8 : RV8;
    m_ar1 = reset ? d1 : RV1;
    m_ar8 = reset ? d8 : RV8;
  end

  // Model rule: asynchronous flop jumps to its reset value when reset falls.
  always @(negedge reset) begin
    m_ar1 = RV1;
    m_ar8 = RV8;
  end

  function automatic logic [26:0] dut_all();
    return {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8};
  endfunction

  function automatic logic [26:0] model_all();
    return {m_nr1, m_sr1, m_ar1, m_nr8, m_sr8, m_ar8};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    d1 = 1'b0;
    d8 = 8'h3C;
    @(posedge clk); #1;
    vectors++;
    if ({q_sr1, q_ar1, q_nr1} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_w1 got=%b exp=000", {q_sr1, q_ar1, q_nr1});
    end
    vectors++;
    if ({q_sr8, q_ar8, q_nr8} !== {8'hA5, 8'hA5, 8'h3C}) begin
      miscompares++;
      $display("FAIL reset_w8 got=%h exp=a5a53c", {q_sr8, q_ar8, q_nr8});
    end
    @(posedge clk); #1;
    vectors++;
    if (dut_all() !== model_all()) begin
      miscompares++;
      $display("FAIL reset_model got=%h exp=%h", dut_all(), model_all());
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    reset = 1'b1;
    d1 = 1'b1;
    d8 = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b111, 8'h3C, 8'h3C, 8'h3C}) begin
        miscompares++;
        $display("FAIL release_cyc%0d got=%h exp=%h", i,
                 {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b111, 8'h3C, 8'h3C, 8'h3C});
      end
    end
  endtask

  task automatic test_async_assert();
    @(negedge clk);
    reset = 1'b0;
    d1 = 1'b1;
    #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b110, 8'h3C, 8'h3C, 8'hA5}) begin
      miscompares++;
      $display("FAIL assert_mid got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b110, 8'h3C, 8'h3C, 8'hA5});
    end
    @(posedge clk); #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b100, 8'h3C, 8'hA5, 8'hA5}) begin
      miscompares++;
      $display("FAIL assert_edge got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b100, 8'h3C, 8'hA5, 8'hA5});
    end
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if ({q_sr1, q_ar1, q_sr8, q_ar8} !== {2'b00, 8'hA5, 8'hA5}) begin
      miscompares++;
      $display("FAIL release_hold got=%h exp=%h", {q_sr1, q_ar1, q_sr8, q_ar8}, {2'b00, 8'hA5, 8'hA5});
    end
    @(posedge clk); #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b111, 8'h3C, 8'h3C, 8'h3C}) begin
      miscompares++;
      $display("FAIL release_edge got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b111, 8'h3C, 8'h3C, 8'h3C});
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b110, 8'h3C, 8'h3C, 8'hA5}) begin
      miscompares++;
      $display("FAIL glitch_low got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b110, 8'h3C, 8'h3C, 8'hA5});
    end
    #1;
    reset = 1'b1;
    #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b110, 8'h3C, 8'h3C, 8'hA5}) begin
      miscompares++;
      $display("FAIL glitch_after got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b110, 8'h3C, 8'h3C, 8'hA5});
    end
    @(posedge clk); #1;
    vectors++;
    if ({q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8} !== {3'b111, 8'h3C, 8'h3C, 8'h3C}) begin
      miscompares++;
      $display("FAIL glitch_edge got=%h exp=%h",
               {q_nr1, q_sr1, q_ar1, q_nr8, q_sr8, q_ar8}, {3'b111, 8'h3C, 8'h3C, 8'h3C});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_all() !== model_all()) begin
        miscompares++;
        $display("FAIL random_pre%0d got=%h exp=%h", i, dut_all(), model_all());
      end
      d1 = 1'($urandom_range(0, 1));
      d8 = 8'($urandom_range(0, 255));
      reset = ($urandom_range(0, 5) != 0) ? 1'b1 : 1'b0;
      #1;
      vectors++;
      if (dut_all() !== model_all()) begin
        miscompares++;
        $display("FAIL random_mid%0d got=%h exp=%h", i, dut_all(), model_all());
      end
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_release();
    test_async_assert();
    test_glitch();
    test_random();
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_ff.md
# d_ff

Reference register block providing three D flip-flop variants side by side, all fed by the same data input: one with no reset, one with synchronous reset and one with asynchronous reset. It is the team's canonical flop-style primitive, used as a leaf cell wherever a registered bit or bus is needed. It also serves as the comparison fixture for reset-style behaviour in waveform reviews.

## Interface
- WIDTH, 1, data width of d_in and of every q output.
- RESET_VAL, '0 (WIDTH bits), value loaded into q_sync_reset and q_async_reset by reset.
- One clock; reset is asynchronous and active-low.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- d_in  input  WIDTH  data captured on every rising clk edge.
- q_no_reset  output  WIDTH  flop output with no reset path.
- q_sync_reset  output  WIDTH  flop output; reset sampled at the clk edge.
- q_async_reset  output  WIDTH  flop output; reset acts immediately.

## Operation
- q_no_reset: on each rising clk edge, loads d_in. Ignores reset entirely. Power-up value is unknown (X in simulation) until the first rising edge.
- q_sync_reset: on each rising clk edge, loads RESET_VAL if reset == 0, else d_in. Between edges, a change on reset has no effect.
- q_async_reset:
  - Forced to RESET_VAL as soon as reset falls, with no clock needed.
  - Held at RESET_VAL while reset == 0.
  - Loads d_in on rising edges while reset == 1.
- All three flops capture the same d_in sample at the same edge. With reset high, all outputs are bit-identical from the first edge onward.
- No enable, no combinational path from d_in to any q. Outputs are driven directly by flops.

## Timing
- Latency d_in -> q: 1 cycle. The value present at a rising edge appears on q after that edge.
- Reset assertion (fall of reset):
  - q_async_reset = RESET_VAL in zero cycles, i.e. mid-cycle.
  - q_sync_reset = RESET_VAL at the next rising edge.
  - q_no_reset is unaffected.
- Reset release (rise of reset):
  - q_async_reset and q_sync_reset both resume loading d_in at the first rising edge at which reset == 1.
  - Release must meet recovery/removal timing. Upstream logic supplies reset synchronously deasserted to clk; the block contains no synchronizer.
- Reset asserted coincident with a rising edge: both reset flops take RESET_VAL at that edge.
- Reset pulse that begins and ends between two edges: q_async_reset shows RESET_VAL until the next edge. q_sync_reset and q_no_reset do not change.

## Structure
- Shared package d_ff_pkg holds:
  - the default RESET_VAL constant;
  - an enum rst_style_e {RST_NONE, RST_SYNC, RST_ASYNC}.
- One natural sub-module, dff_cell, parameterised by WIDTH, RESET_VAL and rst_style_e. d_ff instantiates it three times, once per style.
- Each dff_cell instance uses a single always_ff with the sensitivity list matching its style.

## Test plan
- Power-up, reset = 0, d_in = 0, first edge -> q_sync_reset = q_async_reset = 0. q_no_reset = 0 after the first edge (X before it).
- Release reset = 1, d_in = 1 at an edge -> all three q = 1 one cycle later, held while d_in stays 1.
- Drive reset = 0 at a falling clk edge, d_in = 1:
  - q_async_reset = 0 immediately;
  - q_sync_reset = 0 only at the next rising edge;
  - q_no_reset stays 1.
- Hold reset = 0 for 2 cycles, then release with d_in = 1 -> both reset flops return to 1 at the first rising edge after release.
- Mid-cycle reset glitch of 2 ns, d_in = 1:
  - q_async_reset drops to 0, returns to 1 at the next edge;
  - q_sync_reset and q_no_reset stay 1.
- WIDTH = 8, RESET_VAL = 8'hA5, d_in = 8'h3C -> reset drives both reset flops to 8'hA5; after release all three q = 8'h3C.
